// File: rtl/mult_seq_ctrl_pkg.sv
// mult_seq_ctrl_pkg: state encodings and width helpers for the digit-serial multiplier controller.
package mult_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int idx_w(input int d);
    return (clog2(d) > 1) ? clog2(d) : 1;
  endfunction

  function automatic int sh_w(input int d);
    return (clog2(2 * d - 1) > 1) ? clog2(2 * d - 1) : 1;
  endfunction
endpackage

// File: rtl/mult_step_cnt.sv
// mult_step_cnt: nested down-counter pair walking (a_idx, b_idx) from (DIGITS-1, DIGITS-1) to (0, 0).
module mult_step_cnt #(
  parameter int DIGITS = 2,
  parameter int IDX_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] a_idx,
  output logic [IDX_W-1:0] b_idx,
  output logic             first,
  output logic             last
);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(DIGITS - 1);
  logic [IDX_W-1:0] r_a, r_b;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (clr) begin
      r_a <= '0;
      r_b <= '0;
    end else if (load) begin
      r_a <= TOP;
      r_b <= TOP;
    end else if (en) begin
      r_b <= (r_b == '0) ? TOP : r_b - 1'b1;
      r_a <= (r_b == '0) ? r_a - 1'b1 : r_a;
    end
  end
  assign a_idx = r_a;
  assign b_idx = r_b;
  assign first = (r_a == TOP) && (r_b == TOP);
  assign last  = (r_a == '0) && (r_b == '0);
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: control FSM sequencing all DIGITS x DIGITS partial products with busy/done handshake.
// Define MULT_SEQ_CTRL_ABORT_EN to add the abort input that cancels a RUN without FINISH.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int IDX_W  = idx_w(DIGITS),
  parameter int SH_W   = sh_w(DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MULT_SEQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  output logic [IDX_W-1:0] sel_a,
  output logic [IDX_W-1:0] sel_b,
  output logic [SH_W-1:0]  sel_shifter,
  output logic             data_sel,
  output logic             clk_en,
  output logic             busy,
  output logic             done_flag,
  output logic [1:0]       state
);
  state_t r_state, w_next;
  logic [IDX_W-1:0] w_a, w_b;
  logic w_first, w_last, w_abort, w_run, w_fin;
`ifdef MULT_SEQ_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  assign w_run = (r_state == RUN);
  assign w_fin = (r_state == FINISH);
  mult_step_cnt #(.DIGITS(DIGITS), .IDX_W(IDX_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  ((r_state == IDLE) && start),
    .en    (w_run && !w_last),
    .clr   (w_run && w_abort),
    .a_idx (w_a),
    .b_idx (w_b),
    .first (w_first),
    .last  (w_last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // The unused 2'b11 code falls through to IDLE.
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = start ? RUN : IDLE;
    else if (r_state == RUN) w_next = w_abort ? IDLE : (w_last ? FINISH : RUN);
  end
  assign sel_a       = w_run ? w_a : '0;
  assign sel_b       = w_run ? w_b : '0;
  assign sel_shifter = w_run ? SH_W'(w_a) + SH_W'(w_b) : '0;
  assign data_sel    = w_run ? w_first : 1'b1;
  assign clk_en      = w_run;
  assign busy        = w_run || w_fin;
  assign done_flag   = w_fin;
  assign state       = r_state;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: checks DIGITS=1,2,3 controllers against a queue-of-expected-cycles model.
module tb_mult_seq_ctrl;
  logic clk, rst;
  logic [2:0] s, ab;
  logic [1:0] st1, st2, st3;
  logic [0:0] sa1, sb1, sh1, sa2, sb2;
  logic [1:0] sh2, sa3, sb3;
  logic [2:0] sh3;
  logic ds1, ce1, bz1, dn1, ds2, ce2, bz2, dn2, ds3, ce3, bz3, dn3;
  logic [19:0] q[3][$];
  int total = 0, bad = 0, cnt;

  mult_seq_ctrl #(.DIGITS(1)) d1 (.clk(clk), .rst(rst),
`ifdef MULT_SEQ_CTRL_ABORT_EN
    .abort(ab[0]),
`endif
    .start(s[0]), .sel_a(sa1), .sel_b(sb1), .sel_shifter(sh1), .data_sel(ds1),
    .clk_en(ce1), .busy(bz1), .done_flag(dn1), .state(st1));
  mult_seq_ctrl #(.DIGITS(2)) d2 (.clk(clk), .rst(rst),
`ifdef MULT_SEQ_CTRL_ABORT_EN
    .abort(ab[1]),
`endif
    .start(s[1]), .sel_a(sa2), .sel_b(sb2), .sel_shifter(sh2), .data_sel(ds2),
    .clk_en(ce2), .busy(bz2), .done_flag(dn2), .state(st2));
  mult_seq_ctrl #(.DIGITS(3)) d3 (.clk(clk), .rst(rst),
`ifdef MULT_SEQ_CTRL_ABORT_EN
    .abort(ab[2]),
`endif
    .start(s[2]), .sel_a(sa3), .sel_b(sb3), .sel_shifter(sh3), .data_sel(ds3),
    .clk_en(ce3), .busy(bz3), .done_flag(dn3), .state(st3));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [19:0] pk(input logic [1:0] st, input int a, input int b, input int sh,
                                     input logic d, input logic c, input logic y, input logic n);
    logic [3:0] a4, b4, s4;
    a4 = a[3:0];
    b4 = b[3:0];
    s4 = sh[3:0];
    return {2'b00, st, a4, b4, s4, d, c, y, n};
  endfunction

  function automatic logic [19:0] idle_rec();
    return pk(2'b00, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic push_op(input int i);
    int d;
    d = i + 1;
    for (int a = d - 1; a >= 0; a--)
      for (int b = d - 1; b >= 0; b--)
        q[i].push_back(pk(2'b01, a, b, a + b, (a == d - 1) && (b == d - 1), 1'b1, 1'b1, 1'b0));
    q[i].push_back(pk(2'b10, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1));
  endtask

  function automatic logic abort_hit(input int i);
`ifdef MULT_SEQ_CTRL_ABORT_EN
    return ab[i] && (q[i][0][17:16] == 2'b01);
`else
    return (i < 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_d1"}, pk(st1, int'(sa1), int'(sb1), int'(sh1), ds1, ce1, bz1, dn1),
        q[0].size() != 0 ? q[0][0] : idle_rec());
    chk({tag, "_d2"}, pk(st2, int'(sa2), int'(sb2), int'(sh2), ds2, ce2, bz2, dn2),
        q[1].size() != 0 ? q[1][0] : idle_rec());
    chk({tag, "_d3"}, pk(st3, int'(sa3), int'(sb3), int'(sh3), ds3, ce3, bz3, dn3),
        q[2].size() != 0 ? q[2][0] : idle_rec());
  endtask

  // Called at a falling edge: drive inputs, advance the model at the rising edge, check at the next fall.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [2:0] abt);
    s = st;
    ab = abt;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() == 0) begin
        if (s[i]) push_op(i);
      end else if (abort_hit(i)) q[i].delete();
      else void'(q[i].pop_front());
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    rst = 0;
    s = '0;
    ab = '0;
    @(negedge clk);
    chk_all("reset");
    @(negedge clk);
    rst = 1;
    cyc("start_all", 3'b111, 3'b000);
    for (int k = 0; k < 11; k++) cyc("run_all", 3'b000, 3'b000);
    cyc("rst_pre", 3'b110, 3'b000);
    cyc("rst_pre", 3'b000, 3'b000);
    rst = 0;
    #1;
    for (int i = 0; i < 3; i++) q[i].delete();
    chk_all("rst_async");
    @(negedge clk);
    chk_all("rst_hold");
    rst = 1;
    for (int k = 0; k < 4; k++) cyc("rst_post", 3'b000, 3'b000);
    cnt = 0;
    for (int k = 0; k < 18; k++) begin
      cyc("held", 3'b010, 3'b000);
      cnt += int'(dn2);
    end
    chk("held_done_cnt", 20'(cnt), 20'd3);
    for (int k = 0; k < 12; k++) cyc("drain", 3'b000, 3'b000);
`ifdef MULT_SEQ_CTRL_ABORT_EN
    cyc("ab_start", 3'b010, 3'b000);
    cyc("ab_run2", 3'b000, 3'b000);
    cyc("ab_hit", 3'b000, 3'b010);
    chk("ab_ce", 20'(ce2), 20'd0);
    for (int k = 0; k < 3; k++) cyc("ab_idle", 3'b000, 3'b000);
    cyc("ab_restart", 3'b010, 3'b000);
    for (int k = 0; k < 6; k++) cyc("ab_full", 3'b000, 3'b000);
`endif
    for (int k = 0; k < 200; k++)
      cyc("rand", {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0},
          {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
